// File: rtl/cs_trgt_chan_sync_pkg.sv
// Shared types and helpers for the target-side channel synchroniser.
// Holds the FSM state encoding and the channel-id width rule.
package cs_trgt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      WAIT_RX = 2'd2,
      ERR     = 2'd3
   } cs_trgt_st_e;

   // Bits needed to name n channels, never less than one.
   function automatic int ch_w(int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/cs_trgt_chan_sync_wdog.sv
// Transaction watchdog: cleared at arbitration, counts while enabled,
// flags expiry on the cycle the count reaches MAX-1.
module cs_wdog_cnt #(
   parameter int unsigned MAX = 10000,
   parameter int unsigned W   = $clog2(MAX + 1)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/cs_trgt_chan_sync.sv
// Target-side N-channel bridge: freezes each mission clock on its rising edge,
// optionally uploads the DUT outputs, and releases it once the download arrives.
module cs_trgt_chan_sync
   import cs_trgt_pkg::*;
#(
   parameter int               N_CH     = 4,
   parameter int               DATA_W   = 9,
   parameter logic [N_CH-1:0]  UP_MASK  = N_CH'(4'h8),
   parameter int               WDOG_MAX = 10000,
   localparam int              CH_W     = ch_w(N_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_CH-1:0]          clk_trig_i,
   output logic [N_CH-1:0]          freeze_clk_o,
   input  logic [N_CH*DATA_W-1:0]   up_data_i,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic [CH_W-1:0]          tx_ch_o,
   output logic [DATA_W-1:0]        tx_data_o,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   input  logic [CH_W-1:0]          rx_ch_i,
   input  logic [DATA_W-1:0]        rx_data_i,
   output logic [N_CH*DATA_W-1:0]   dn_data_o,
   output logic [N_CH-1:0]          dn_upd_o,
   output logic                     busy_o,
   output logic                     wdog_err_o,
   output logic                     overrun_o,
   output logic                     bad_ch_o
);

   cs_trgt_st_e              state_q, state_d;
   logic [N_CH-1:0]          trig_q;
   logic [N_CH-1:0]          pend_q, pend_d;
   logic [N_CH-1:0]          freeze_q, freeze_d;
   logic [N_CH-1:0]          dn_upd_q, dn_upd_d;
   logic [N_CH*DATA_W-1:0]   dn_data_q, dn_data_d;
   logic [CH_W-1:0]          cur_q, cur_d;
   logic [DATA_W-1:0]        tx_data_q, tx_data_d;
   logic                     wdog_err_q, wdog_err_d;
   logic                     overrun_q, overrun_d;
   logic                     bad_ch_q, bad_ch_d;

   logic [N_CH-1:0]          rise;
   logic [N_CH-1:0]          ch_hit;
   logic [N_CH-1:0]          done;
   logic                     rx_acc;
   logic                     done_any;
   logic [CH_W-1:0]          lo_idx;
   logic                     lo_up;
   logic [DATA_W-1:0]        lo_data;
   logic                     wdog_clr, wdog_en, wdog_exp;

   assign rise     = clk_trig_i & ~trig_q;
   assign rx_acc   = rx_valid_i && (state_q == WAIT_RX);
   assign done_any = |done;

   // Per-channel decode of the download id; done marks the channel being served.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign ch_hit[gi] = rx_acc && (rx_ch_i == CH_W'(gi));
         assign done[gi]   = ch_hit[gi] && (cur_q == CH_W'(gi));
      end
   endgenerate

   // Lowest pending channel wins arbitration.
   always_comb begin
      lo_idx  = '0;
      lo_up   = 1'b0;
      lo_data = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (pend_q[c]) begin
            lo_idx  = CH_W'(c);
            lo_up   = UP_MASK[c];
            lo_data = up_data_i[c*DATA_W +: DATA_W];
         end
      end
   end

   // Completion clears before a same-cycle edge re-arms, so that case is not an overrun.
   always_comb begin
      pend_d    = (pend_q & ~done) | rise;
      freeze_d  = (freeze_q & ~done) | rise;
      overrun_d = overrun_q | (|(rise & pend_q & ~done));
      bad_ch_d  = bad_ch_q | (rx_acc && (ch_hit == '0));
      dn_upd_d  = ch_hit;
      dn_data_d = dn_data_q;
      for (int c = 0; c < N_CH; c++) begin
         if (ch_hit[c]) begin
            dn_data_d[c*DATA_W +: DATA_W] = rx_data_i;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      tx_data_d  = tx_data_q;
      wdog_err_d = wdog_err_q;
      wdog_clr   = 1'b0;
      wdog_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q != '0) begin
               cur_d     = lo_idx;
               tx_data_d = lo_data;
               wdog_clr  = 1'b1;
               state_d   = lo_up ? SEND : WAIT_RX;
            end
         end
         SEND: begin
            wdog_en = 1'b1;
            if (tx_ready_i) begin
               state_d = WAIT_RX;
            end else if (wdog_exp) begin
               state_d    = ERR;
               wdog_err_d = 1'b1;
            end
         end
         WAIT_RX: begin
            wdog_en = 1'b1;
            if (done_any) begin
               state_d = IDLE;
            end else if (wdog_exp) begin
               state_d    = ERR;
               wdog_err_d = 1'b1;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         trig_q     <= '0;
         pend_q     <= '0;
         freeze_q   <= '0;
         dn_upd_q   <= '0;
         dn_data_q  <= '0;
         cur_q      <= '0;
         tx_data_q  <= '0;
         wdog_err_q <= 1'b0;
         overrun_q  <= 1'b0;
         bad_ch_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_q     <= clk_trig_i;
         pend_q     <= pend_d;
         freeze_q   <= freeze_d;
         dn_upd_q   <= dn_upd_d;
         dn_data_q  <= dn_data_d;
         cur_q      <= cur_d;
         tx_data_q  <= tx_data_d;
         wdog_err_q <= wdog_err_d;
         overrun_q  <= overrun_d;
         bad_ch_q   <= bad_ch_d;
      end
   end

   cs_wdog_cnt #(
      .MAX (WDOG_MAX)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (wdog_clr),
      .en_i     (wdog_en),
      .expire_o (wdog_exp)
   );

   assign freeze_clk_o = freeze_q;
   assign tx_valid_o   = (state_q == SEND);
   assign tx_ch_o      = cur_q;
   assign tx_data_o    = tx_data_q;
   assign rx_ready_o   = (state_q == WAIT_RX);
   assign dn_data_o    = dn_data_q;
   assign dn_upd_o     = dn_upd_q;
   assign busy_o       = (state_q != IDLE);
   assign wdog_err_o   = wdog_err_q;
   assign overrun_o    = overrun_q;
   assign bad_ch_o     = bad_ch_q;

endmodule

// File: tb/tb_cs_trgt_chan_sync.sv
// Directed bench for cs_trgt_chan_sync: five-channel build (3-bit ids) with
// upload on channel 3 only and a 16-cycle watchdog.
module tb_cs_trgt_chan_sync;

   localparam int NC = 5;
   localparam int DW = 9;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NC-1:0]     trig;
   logic [NC*DW-1:0]  up_data;
   logic              tx_ready;
   logic              rx_valid;
   logic [2:0]        rx_ch;
   logic [DW-1:0]     rx_data;
   logic [NC-1:0]     freeze;
   logic              tx_valid;
   logic [2:0]        tx_ch;
   logic [DW-1:0]     tx_data;
   logic              rx_ready;
   logic [NC*DW-1:0]  dn_data;
   logic [NC-1:0]     dn_upd;
   logic              busy, wdog_err, overrun, bad_ch;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cs_trgt_chan_sync #(
      .N_CH     (NC),
      .DATA_W   (DW),
      .UP_MASK  (5'h08),
      .WDOG_MAX (16)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clk_trig_i   (trig),
      .freeze_clk_o (freeze),
      .up_data_i    (up_data),
      .tx_valid_o   (tx_valid),
      .tx_ready_i   (tx_ready),
      .tx_ch_o      (tx_ch),
      .tx_data_o    (tx_data),
      .rx_valid_i   (rx_valid),
      .rx_ready_o   (rx_ready),
      .rx_ch_i      (rx_ch),
      .rx_data_i    (rx_data),
      .dn_data_o    (dn_data),
      .dn_upd_o     (dn_upd),
      .busy_o       (busy),
      .wdog_err_o   (wdog_err),
      .overrun_o    (overrun),
      .bad_ch_o     (bad_ch)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; trig = '0; up_data = '0; tx_ready = 1'b0;
      rx_valid = 1'b0; rx_ch = '0; rx_data = '0;
      repeat (3) step();
      n_cmp++; if ({freeze, tx_valid, rx_ready, busy} !== 8'h00) begin n_bad++; $display("FAIL reset_ctl: got %h expected 00", {freeze, tx_valid, rx_ready, busy}); end
      n_cmp++; if ({wdog_err, overrun, bad_ch, dn_upd} !== 8'h00) begin n_bad++; $display("FAIL reset_flags: got %h expected 00", {wdog_err, overrun, bad_ch, dn_upd}); end
      n_cmp++; if (dn_data !== '0 || tx_data !== '0 || tx_ch !== '0) begin n_bad++; $display("FAIL reset_data: got dn %h tx %h ch %h expected 0", dn_data, tx_data, tx_ch); end
      rst_n = 1'b1;
      step();
      $display("txn reset released");
   endtask

   task automatic test_wait_only();
      trig[0] = 1'b1;
      step();
      n_cmp++; if (freeze !== 5'b00001 || busy !== 1'b0) begin n_bad++; $display("FAIL t1_freeze: got frz %b busy %b expected 00001 0", freeze, busy); end
      step();
      n_cmp++; if ({busy, rx_ready, tx_valid} !== 3'b110) begin n_bad++; $display("FAIL t1_wait: got %b expected 110", {busy, rx_ready, tx_valid}); end
      step();
      rx_valid = 1'b1; rx_ch = 3'd0; rx_data = 9'h1A5;
      step();
      rx_valid = 1'b0; trig[0] = 1'b0;
      n_cmp++; if (dn_data[0 +: DW] !== 9'h1A5) begin n_bad++; $display("FAIL t1_dn: got %h expected 1a5", dn_data[0 +: DW]); end
      n_cmp++; if (dn_upd !== 5'b00001 || freeze !== 5'b00000 || busy !== 1'b0) begin n_bad++; $display("FAIL t1_done: got upd %b frz %b busy %b expected 00001 00000 0", dn_upd, freeze, busy); end
      step();
      n_cmp++; if (dn_upd !== 5'b00000) begin n_bad++; $display("FAIL t1_pulse: got %b expected 00000", dn_upd); end
      $display("txn ch0 wait-only dn=%h", dn_data[0 +: DW]);
   endtask

   task automatic test_upload_stall();
      up_data[3*DW +: DW] = 9'h155;
      trig[3] = 1'b1;
      step();
      step();
      up_data[3*DW +: DW] = 9'h0AA;
      n_cmp++; if ({tx_valid, rx_ready} !== 2'b10 || tx_ch !== 3'd3 || tx_data !== 9'h155) begin n_bad++; $display("FAIL t2_send: got v/r %b ch %0d d %h expected 10 3 155", {tx_valid, rx_ready}, tx_ch, tx_data); end
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 9'h155) begin n_bad++; $display("FAIL t2_hold%0d: got v %b d %h expected 1 155", i, tx_valid, tx_data); end
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      n_cmp++; if ({tx_valid, rx_ready, freeze[3]} !== 3'b011) begin n_bad++; $display("FAIL t2_wait: got %b expected 011", {tx_valid, rx_ready, freeze[3]}); end
      rx_valid = 1'b1; rx_ch = 3'd3; rx_data = 9'h000;
      step();
      rx_valid = 1'b0; trig[3] = 1'b0;
      n_cmp++; if (dn_upd !== 5'b01000 || freeze !== 5'b00000 || busy !== 1'b0) begin n_bad++; $display("FAIL t2_done: got upd %b frz %b busy %b expected 01000 00000 0", dn_upd, freeze, busy); end
      $display("txn ch3 upload 155 after stall");
   endtask

   task automatic test_edge_complete();
      trig[0] = 1'b1;
      step();
      trig[0] = 1'b0;
      step();
      rx_valid = 1'b1; rx_ch = 3'd0; rx_data = 9'h033; trig[0] = 1'b1;
      step();
      rx_valid = 1'b0;
      n_cmp++; if (freeze !== 5'b00001 || overrun !== 1'b0 || dn_upd !== 5'b00001 || busy !== 1'b0) begin n_bad++; $display("FAIL t_ec_rearm: got frz %b ovr %b upd %b busy %b expected 00001 0 00001 0", freeze, overrun, dn_upd, busy); end
      step();
      n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL t_ec_rearb: got %b expected 1", rx_ready); end
      rx_valid = 1'b1; rx_data = 9'h044;
      step();
      rx_valid = 1'b0; trig[0] = 1'b0;
      n_cmp++; if (freeze !== 5'b00000 || dn_data[0 +: DW] !== 9'h044) begin n_bad++; $display("FAIL t_ec_done: got frz %b dn %h expected 00000 044", freeze, dn_data[0 +: DW]); end
      step();
      $display("txn ch0 edge+completion, then ch0 again");
   endtask

   task automatic test_same_cycle_edges();
      trig[1] = 1'b1; trig[2] = 1'b1;
      step();
      step();
      n_cmp++; if (rx_ready !== 1'b1 || freeze !== 5'b00110) begin n_bad++; $display("FAIL t3_arb: got rdy %b frz %b expected 1 00110", rx_ready, freeze); end
      rx_valid = 1'b1; rx_ch = 3'd1; rx_data = 9'h011;
      step();
      rx_valid = 1'b0;
      n_cmp++; if (dn_upd !== 5'b00010 || freeze !== 5'b00100) begin n_bad++; $display("FAIL t3_first: got upd %b frz %b expected 00010 00100", dn_upd, freeze); end
      step();
      n_cmp++; if (rx_ready !== 1'b1 || freeze[2] !== 1'b1) begin n_bad++; $display("FAIL t3_second: got rdy %b frz2 %b expected 1 1", rx_ready, freeze[2]); end
      rx_valid = 1'b1; rx_ch = 3'd2; rx_data = 9'h022;
      step();
      rx_valid = 1'b0; trig[1] = 1'b0; trig[2] = 1'b0;
      n_cmp++; if (dn_data[2*DW +: DW] !== 9'h022 || dn_data[1*DW +: DW] !== 9'h011 || freeze !== 5'b00000 || busy !== 1'b0) begin n_bad++; $display("FAIL t3_done: got dn2 %h dn1 %h frz %b busy %b expected 022 011 00000 0", dn_data[2*DW +: DW], dn_data[1*DW +: DW], freeze, busy); end
      step();
      $display("txn ch1 then ch2");
   endtask

   task automatic test_overrun();
      trig[0] = 1'b1;
      step();
      trig[0] = 1'b0;
      step();
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL t4_pre: got %b expected 0", overrun); end
      trig[0] = 1'b1;
      step();
      n_cmp++; if (overrun !== 1'b1 || freeze !== 5'b00001) begin n_bad++; $display("FAIL t4_ovr: got ovr %b frz %b expected 1 00001", overrun, freeze); end
      rx_valid = 1'b1; rx_ch = 3'd0; rx_data = 9'h0F0;
      step();
      rx_valid = 1'b0;
      n_cmp++; if (dn_upd !== 5'b00001 || busy !== 1'b0) begin n_bad++; $display("FAIL t4_done: got upd %b busy %b expected 00001 0", dn_upd, busy); end
      step();
      trig[0] = 1'b0;
      n_cmp++; if (busy !== 1'b0 || freeze !== 5'b00000) begin n_bad++; $display("FAIL t4_single: got busy %b frz %b expected 0 00000", busy, freeze); end
      step();
      $display("txn ch0 overrun, single service");
   endtask

   task automatic test_bad_and_other_ch();
      trig[4] = 1'b1;
      step();
      step();
      rx_valid = 1'b1; rx_ch = 3'd5; rx_data = 9'h1FF;
      step();
      n_cmp++; if (bad_ch !== 1'b1 || rx_ready !== 1'b1 || dn_upd !== 5'b00000) begin n_bad++; $display("FAIL t5_bad: got bad %b rdy %b upd %b expected 1 1 00000", bad_ch, rx_ready, dn_upd); end
      rx_ch = 3'd1; rx_data = 9'h101;
      step();
      n_cmp++; if (dn_upd !== 5'b00010 || dn_data[1*DW +: DW] !== 9'h101 || rx_ready !== 1'b1 || freeze !== 5'b10000) begin n_bad++; $display("FAIL t5_other: got upd %b dn1 %h rdy %b frz %b expected 00010 101 1 10000", dn_upd, dn_data[1*DW +: DW], rx_ready, freeze); end
      rx_ch = 3'd4; rx_data = 9'h144;
      step();
      rx_valid = 1'b0; trig[4] = 1'b0;
      n_cmp++; if (dn_data[4*DW +: DW] !== 9'h144 || freeze !== 5'b00000 || busy !== 1'b0) begin n_bad++; $display("FAIL t5_done: got dn4 %h frz %b busy %b expected 144 00000 0", dn_data[4*DW +: DW], freeze, busy); end
      step();
      $display("txn ch4 with bad id and ch1 side update");
   endtask

   task automatic test_watchdog_reset();
      trig[0] = 1'b1;
      step();
      step();
      repeat (15) step();
      n_cmp++; if (rx_ready !== 1'b1 || wdog_err !== 1'b0) begin n_bad++; $display("FAIL t6_pre: got rdy %b err %b expected 1 0", rx_ready, wdog_err); end
      step();
      n_cmp++; if (wdog_err !== 1'b1 || rx_ready !== 1'b0 || tx_valid !== 1'b0 || freeze !== 5'b00001) begin n_bad++; $display("FAIL t6_err: got err %b rdy %b tv %b frz %b expected 1 0 0 00001", wdog_err, rx_ready, tx_valid, freeze); end
      rx_valid = 1'b1; rx_ch = 3'd0; rx_data = 9'h077;
      step();
      rx_valid = 1'b0;
      n_cmp++; if (dn_upd !== 5'b00000 || dn_data[0 +: DW] !== 9'h0F0 || busy !== 1'b1) begin n_bad++; $display("FAIL t6_noacc: got upd %b dn0 %h busy %b expected 00000 0f0 1", dn_upd, dn_data[0 +: DW], busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({freeze, tx_valid, rx_ready, busy, wdog_err, overrun, bad_ch} !== 11'h000 || dn_data !== '0) begin n_bad++; $display("FAIL t6_rst: got %b dn %h expected all 0", {freeze, tx_valid, rx_ready, busy, wdog_err, overrun, bad_ch}, dn_data); end
      $display("txn ch0 watchdog expiry then reset");
   endtask

   initial begin
      test_reset();
      test_wait_only();
      test_upload_stall();
      test_edge_complete();
      test_same_cycle_edges();
      test_overrun();
      test_bad_and_other_ch();
      test_watchdog_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
